// File: rtl/mult_div_seq.sv
// Sequential signed 32x32 multiply (radix-2 Booth) / divide (restoring on magnitudes)
// feeding the Hi/Lo registers; 32 iterations, then sign fix-up and a one-cycle done pulse.
module mult_div_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        op,
    input  logic [31:0] a_in,
    input  logic [31:0] b_in,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done,
    output logic        div0
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MULT,
        S_DIV,
        S_FIX,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] acc_q, acc_d;     // Booth accumulator / division remainder
    logic [31:0] q_q, q_d;         // Booth multiplier / dividend shifting into quotient
    logic        qm1_q, qm1_d;
    logic [31:0] m_q, m_d;         // multiplicand / divisor magnitude
    logic        op_q, op_d;
    logic        div0_q, div0_d;
    logic        quo_neg_q, quo_neg_d;
    logic        rem_neg_q, rem_neg_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic [31:0] a_mag, b_mag;
    logic [32:0] booth_sum;
    logic [32:0] shifted;
    logic [31:0] trial_diff;
    logic        trial_ge;

    // Datapath helpers, shared by the FSM below.
    always_comb begin
        a_mag = a_in[31] ? (~a_in + 32'd1) : a_in;
        b_mag = b_in[31] ? (~b_in + 32'd1) : b_in;

        // The sum is taken one bit wider so a -2^31 multiplicand cannot overflow
        // before the arithmetic shift brings it back into 32 bits.
        case ({q_q[0], qm1_q})
            2'b01:   booth_sum = {acc_q[31], acc_q} + {m_q[31], m_q};
            2'b10:   booth_sum = {acc_q[31], acc_q} - {m_q[31], m_q};
            default: booth_sum = {acc_q[31], acc_q};
        endcase

        shifted    = {acc_q, q_q[31]};
        trial_ge   = (shifted >= {1'b0, m_q});
        trial_diff = shifted[31:0] - m_q;
    end

    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        q_d       = q_q;
        qm1_d     = qm1_q;
        m_d       = m_q;
        op_d      = op_q;
        div0_d    = div0_q;
        quo_neg_d = quo_neg_q;
        rem_neg_d = rem_neg_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d   = op;
                    cnt_d  = 6'd32;
                    acc_d  = 32'd0;
                    qm1_d  = 1'b0;
                    div0_d = 1'b0;
                    if (op) begin
                        q_d       = a_mag;
                        m_d       = b_mag;
                        quo_neg_d = a_in[31] ^ b_in[31];
                        rem_neg_d = a_in[31];
                        // Divide-by-zero skips the iterations but still spends one
                        // cycle in FIX, which leaves hi/lo untouched.
                        if (b_in == 32'd0) begin
                            div0_d  = 1'b1;
                            state_d = S_FIX;
                        end else begin
                            state_d = S_DIV;
                        end
                    end else begin
                        q_d     = b_in;
                        m_d     = a_in;
                        state_d = S_MULT;
                    end
                end
            end

            S_MULT: begin
                acc_d = booth_sum[32:1];
                q_d   = {booth_sum[0], q_q[31:1]};
                qm1_d = q_q[0];
                cnt_d = cnt_q - 6'd1;
                if (cnt_q == 6'd1) begin
                    state_d = S_FIX;
                end
            end

            S_DIV: begin
                if (trial_ge) begin
                    acc_d = trial_diff;
                    q_d   = {q_q[30:0], 1'b1};
                end else begin
                    acc_d = shifted[31:0];
                    q_d   = {q_q[30:0], 1'b0};
                end
                cnt_d = cnt_q - 6'd1;
                if (cnt_q == 6'd1) begin
                    state_d = S_FIX;
                end
            end

            S_FIX: begin
                if (!div0_q) begin
                    if (op_q) begin
                        lo_d = quo_neg_q ? (~q_q + 32'd1) : q_q;
                        hi_d = rem_neg_q ? (~acc_q + 32'd1) : acc_q;
                    end else begin
                        hi_d = acc_q;
                        lo_d = q_q;
                    end
                end
                state_d = S_DONE;
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= 6'd0;
            acc_q     <= 32'd0;
            q_q       <= 32'd0;
            qm1_q     <= 1'b0;
            m_q       <= 32'd0;
            op_q      <= 1'b0;
            div0_q    <= 1'b0;
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            q_q       <= q_d;
            qm1_q     <= qm1_d;
            m_q       <= m_d;
            op_q      <= op_d;
            div0_q    <= div0_d;
            quo_neg_q <= quo_neg_d;
            rem_neg_q <= rem_neg_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign busy = (state_q != S_IDLE);
    assign done = (state_q == S_DONE);
    assign div0 = (state_q == S_DONE) && div0_q;

endmodule
